frv_gpr_writer: RTL and testbench

//  Write-side master for the 2-bank (even/odd) GPR file. Merges writeback from the
//  in-order pipeline (pipe) and from long-latency units (long: mul/div/load) onto the

---
 rtl/frv_gpr_writer_pkg.sv | 50 +++++
 rtl/frv_gpr_wr_fifo.sv | 70 +++++++
 rtl/frv_gpr_writer.sv | 174 +++++++++++++++++
 tb/tb_frv_gpr_writer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/frv_gpr_writer_pkg.sv
// ----------------------------------------------------------------------------
// frv_gpr_writer_pkg
//   Shared types and helpers for the GPR write-side master.
//   - gpr_wr_req_t : one GPR write request {wide, addr, wdata}
//   - wr_src_e     : which source owns the GPR write port in a given cycle
//   - gpr_norm_addr: forces wide destinations to the even register of the pair
//   - gpr_mask     : one-hot (or two-hot for wide) register mask, x0 excluded
// ----------------------------------------------------------------------------
package frv_gpr_writer_pkg;

    localparam int unsigned GPR_ADDR_W = 5;
    localparam int unsigned GPR_NUM    = 32;

    typedef struct packed {
        logic                  wide;
        logic [GPR_ADDR_W-1:0] addr;
        logic [63:0]           wdata;
    } gpr_wr_req_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_PIPE = 2'd1,
        SRC_LONG = 2'd2
    } wr_src_e;

    function automatic logic [GPR_ADDR_W-1:0] gpr_norm_addr(
        input logic                  wide,
        input logic [GPR_ADDR_W-1:0] addr
    );
        return wide ? {addr[GPR_ADDR_W-1:1], 1'b0} : addr;
    endfunction

    // x0 is hard-wired zero, so its bit is never part of a mask.
    function automatic logic [GPR_NUM-1:0] gpr_mask(
        input logic                  wide,
        input logic [GPR_ADDR_W-1:0] addr
    );
        logic [GPR_ADDR_W-1:0] base;
        logic [GPR_NUM-1:0]    m;
        base    = gpr_norm_addr(wide, addr);
        m       = '0;
        m[base] = 1'b1;
        if (wide) begin
            m[base | GPR_ADDR_W'(1)] = 1'b1;
        end
        m[0] = 1'b0;
        return m;
    endfunction

endpackage

// File: rtl/frv_gpr_wr_fifo.sv
// ----------------------------------------------------------------------------
// frv_gpr_wr_fifo
//   Synchronous FIFO of gpr_wr_req_t used to buffer long-latency results.
//   Ports:
//     clk_i, rst_i  : clock, synchronous active-high reset (empties the FIFO)
//     push_i        : write push_data_i (accepted when not full, or when full
//                     and popping in the same cycle)
//     push_data_i   : request to enqueue
//     pop_i         : drop the head entry (ignored when empty)
//     head_o        : current head entry
//     full_o/empty_o: occupancy flags, derived from registered count
// ----------------------------------------------------------------------------
module frv_gpr_wr_fifo
    import frv_gpr_writer_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        push_i,
    input  gpr_wr_req_t push_data_i,
    input  logic        pop_i,
    output gpr_wr_req_t head_o,
    output logic        full_o,
    output logic        empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    gpr_wr_req_t      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/frv_gpr_writer.sv
// ----------------------------------------------------------------------------
// frv_gpr_writer
//   Write-side master for the 2-bank GPR file. Merges in-order pipe writeback
//   and buffered long-latency results onto the single GPR write port, and
//   keeps a scoreboard of destinations still waiting for a long result.
//   Ports:
//     g_clk, g_reset               : clock, synchronous active-high reset
//     pipe_valid/ready/wide/addr/wdata : pipe writeback handshake + payload
//     long_valid/ready/wide/addr/wdata : long-unit result handshake + payload
//     claim_valid/wide/addr        : issue reserves a long destination
//     busy                         : scoreboard, bit n = xn pending
//     rd_wen/wide/addr/wdata/wdata_hi : registered GPR write port
//     wide_err                     : pulse, wide request had an odd address
// ----------------------------------------------------------------------------
module frv_gpr_writer
    import frv_gpr_writer_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                  g_clk,
    input  logic                  g_reset,
    input  logic                  pipe_valid,
    output logic                  pipe_ready,
    input  logic                  pipe_wide,
    input  logic [GPR_ADDR_W-1:0] pipe_addr,
    input  logic [63:0]           pipe_wdata,
    input  logic                  long_valid,
    output logic                  long_ready,
    input  logic                  long_wide,
    input  logic [GPR_ADDR_W-1:0] long_addr,
    input  logic [63:0]           long_wdata,
    input  logic                  claim_valid,
    input  logic                  claim_wide,
    input  logic [GPR_ADDR_W-1:0] claim_addr,
    output logic [GPR_NUM-1:0]    busy,
    output logic                  rd_wen,
    output logic                  rd_wide,
    output logic [GPR_ADDR_W-1:0] rd_addr,
    output logic [31:0]           rd_wdata,
    output logic [31:0]           rd_wdata_hi,
    output logic                  wide_err
);

    localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);

    // ---------------- long-result FIFO ----------------
    gpr_wr_req_t long_req, fifo_head, pipe_req, sel_req;
    logic        fifo_push, fifo_pop, fifo_full, fifo_empty;

    assign long_req  = '{wide: long_wide, addr: long_addr, wdata: long_wdata};
    assign pipe_req  = '{wide: pipe_wide, addr: pipe_addr, wdata: pipe_wdata};

    // Full flag comes straight from the FIFO's registered count.
    assign long_ready = !fifo_full;
    assign fifo_push  = long_valid && long_ready;

    frv_gpr_wr_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (g_clk),
        .rst_i       (g_reset),
        .push_i      (fifo_push),
        .push_data_i (long_req),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // ---------------- arbitration and starvation ----------------
    logic [STARVE_W-1:0] starve_q, starve_d;
    wr_src_e             sel_src;

    // Withholding pipe_ready for one cycle guarantees the head pops below.
    assign pipe_ready = (starve_q != STARVE_W'(STARVE_MAX));

    always_comb begin
        sel_src  = SRC_NONE;
        sel_req  = '0;
        fifo_pop = 1'b0;
        if (pipe_valid && pipe_ready) begin
            sel_src = SRC_PIPE;
            sel_req = pipe_req;
        end else if (!fifo_empty) begin
            sel_src  = SRC_LONG;
            sel_req  = fifo_head;
            fifo_pop = 1'b1;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (fifo_pop) begin
            starve_d = '0;
        end else if (fifo_full) begin
            starve_d = starve_q + STARVE_W'(1);
        end
    end

    // ---------------- output stage ----------------
    logic                  rd_wen_q,  rd_wen_d;
    logic                  rd_wide_q, rd_wide_d;
    logic                  rd_long_q, rd_long_d;
    logic                  werr_q,    werr_d;
    logic [GPR_ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [63:0]           rd_data_q, rd_data_d;

    always_comb begin
        rd_wen_d  = 1'b0;
        rd_wide_d = 1'b0;
        rd_long_d = 1'b0;
        werr_d    = 1'b0;
        rd_addr_d = rd_addr_q;
        rd_data_d = rd_data_q;
        if (sel_src != SRC_NONE) begin
            // Non-wide x0 writes complete the handshake but never reach the file.
            rd_wen_d  = sel_req.wide || (sel_req.addr != '0);
            rd_wide_d = sel_req.wide;
            rd_long_d = (sel_src == SRC_LONG);
            werr_d    = sel_req.wide && sel_req.addr[0];
            rd_addr_d = gpr_norm_addr(sel_req.wide, sel_req.addr);
            rd_data_d = sel_req.wdata;
        end
    end

    // ---------------- scoreboard ----------------
    logic [GPR_NUM-1:0] busy_q, busy_d, busy_set, busy_clr;

    always_comb begin
        busy_set = '0;
        busy_clr = '0;
        if (claim_valid) begin
            busy_set = gpr_mask(claim_wide, claim_addr);
        end
        if (rd_wen_q && rd_long_q) begin
            busy_clr = gpr_mask(rd_wide_q, rd_addr_q);
        end
        // Set after clear: a fresh claim outlives a same-cycle commit.
        busy_d    = (busy_q & ~busy_clr) | busy_set;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            starve_q  <= '0;
            rd_wen_q  <= 1'b0;
            rd_wide_q <= 1'b0;
            rd_long_q <= 1'b0;
            werr_q    <= 1'b0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
            busy_q    <= '0;
        end else begin
            starve_q  <= starve_d;
            rd_wen_q  <= rd_wen_d;
            rd_wide_q <= rd_wide_d;
            rd_long_q <= rd_long_d;
            werr_q    <= werr_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
            busy_q    <= busy_d;
        end
    end

    assign busy        = busy_q;
    assign rd_wen      = rd_wen_q;
    assign rd_wide     = rd_wide_q;
    assign rd_addr     = rd_addr_q;
    assign rd_wdata    = rd_data_q[31:0];
    assign rd_wdata_hi = rd_data_q[63:32];
    assign wide_err    = werr_q;

endmodule

// File: tb/tb_frv_gpr_writer.sv
module tb_frv_gpr_writer;

    logic        g_clk = 1'b0;
    logic        g_reset;
    logic        pipe_valid, pipe_ready, pipe_wide;
    logic [4:0]  pipe_addr;
    logic [63:0] pipe_wdata;
    logic        long_valid, long_ready, long_wide;
    logic [4:0]  long_addr;
    logic [63:0] long_wdata;
    logic        claim_valid, claim_wide;
    logic [4:0]  claim_addr;
    logic [31:0] busy;
    logic        rd_wen, rd_wide, wide_err;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata, rd_wdata_hi;

    int vectors = 0;
    int errors  = 0;

    frv_gpr_writer #(
        .FIFO_DEPTH(2),
        .STARVE_MAX(4)
    ) dut (
        .g_clk       (g_clk),
        .g_reset     (g_reset),
        .pipe_valid  (pipe_valid),
        .pipe_ready  (pipe_ready),
        .pipe_wide   (pipe_wide),
        .pipe_addr   (pipe_addr),
        .pipe_wdata  (pipe_wdata),
        .long_valid  (long_valid),
        .long_ready  (long_ready),
        .long_wide   (long_wide),
        .long_addr   (long_addr),
        .long_wdata  (long_wdata),
        .claim_valid (claim_valid),
        .claim_wide  (claim_wide),
        .claim_addr  (claim_addr),
        .busy        (busy),
        .rd_wen      (rd_wen),
        .rd_wide     (rd_wide),
        .rd_addr     (rd_addr),
        .rd_wdata    (rd_wdata),
        .rd_wdata_hi (rd_wdata_hi),
        .wide_err    (wide_err)
    );

    always #5 g_clk = ~g_clk;

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected handshake pattern with pipe and long both requesting every cycle.
    bit exp_pr [13] = '{1, 1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 1, 0};
    bit exp_lr [13] = '{1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};

    initial begin
        int li;
        g_reset     = 1'b1;
        pipe_valid  = 1'b0; pipe_wide = 1'b0; pipe_addr = '0; pipe_wdata = '0;
        long_valid  = 1'b0; long_wide = 1'b0; long_addr = '0; long_wdata = '0;
        claim_valid = 1'b0; claim_wide = 1'b0; claim_addr = '0;
        tick();
        tick();

        // Reset state
        chk("rst_rd_wen", rd_wen, 0);
        chk("rst_rd_wide", rd_wide, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_rd_wdata", rd_wdata, 0);
        chk("rst_rd_wdata_hi", rd_wdata_hi, 0);
        chk("rst_wide_err", wide_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pipe_ready", pipe_ready, 1);
        chk("rst_long_ready", long_ready, 1);
        g_reset = 1'b0;
        tick();

        // 1. Pipe alone
        pipe_valid = 1'b1; pipe_addr = 5'd5; pipe_wdata = 64'h0000_0000_DEAD_BEEF;
        chk("t1_pipe_ready", pipe_ready, 1);
        tick();
        pipe_valid = 1'b0;
        chk("t1_rd_wen", rd_wen, 1);
        chk("t1_rd_addr", rd_addr, 5);
        chk("t1_rd_wdata", rd_wdata, 32'hDEAD_BEEF);
        chk("t1_rd_wide", rd_wide, 0);
        tick();
        chk("t1_idle_rd_wen", rd_wen, 0);
        chk("t1_idle_hold_wdata", rd_wdata, 32'hDEAD_BEEF);

        // 2. Wide claim then wide long write to x8
        claim_valid = 1'b1; claim_wide = 1'b1; claim_addr = 5'd8;
        tick();
        claim_valid = 1'b0;
        chk("t2_busy_claimed", busy, 32'h0000_0300);
        long_valid = 1'b1; long_wide = 1'b1; long_addr = 5'd8; long_wdata = {32'd1, 32'd2};
        chk("t2_long_ready", long_ready, 1);
        tick();
        long_valid = 1'b0;
        chk("t2_busy_buffered", busy, 32'h0000_0300);
        chk("t2_wen_buffered", rd_wen, 0);
        tick();
        chk("t2_rd_wen", rd_wen, 1);
        chk("t2_rd_wide", rd_wide, 1);
        chk("t2_rd_addr", rd_addr, 8);
        chk("t2_rd_wdata", rd_wdata, 2);
        chk("t2_rd_wdata_hi", rd_wdata_hi, 1);
        chk("t2_busy_write_cycle", busy, 32'h0000_0300);
        tick();
        chk("t2_busy_cleared", busy, 0);
        chk("t2_rd_wen_idle", rd_wen, 0);

        // 4. Non-wide x0 pipe write, then wide long write to odd x3
        pipe_valid = 1'b1; pipe_wide = 1'b0; pipe_addr = 5'd0; pipe_wdata = 64'h1234;
        chk("t4_x0_pipe_ready", pipe_ready, 1);
        tick();
        pipe_valid = 1'b0;
        chk("t4_x0_rd_wen", rd_wen, 0);
        chk("t4_x0_wide_err", wide_err, 0);
        long_valid = 1'b1; long_wide = 1'b1; long_addr = 5'd3; long_wdata = 64'h0000_0033_0000_0022;
        tick();
        long_valid = 1'b0;
        chk("t4_err_before", wide_err, 0);
        tick();
        chk("t4_odd_rd_wen", rd_wen, 1);
        chk("t4_odd_rd_addr", rd_addr, 2);
        chk("t4_odd_rd_wide", rd_wide, 1);
        chk("t4_odd_wide_err", wide_err, 1);
        chk("t4_odd_wdata_hi", rd_wdata_hi, 32'h33);
        tick();
        chk("t4_err_after", wide_err, 0);

        // 5. Claim on x7 coincides with a long commit to x7
        claim_valid = 1'b1; claim_wide = 1'b0; claim_addr = 5'd7;
        tick();
        claim_valid = 1'b0;
        chk("t5_busy_claimed", busy, 32'h0000_0080);
        long_valid = 1'b1; long_wide = 1'b0; long_addr = 5'd7; long_wdata = 64'h77;
        tick();
        long_valid = 1'b0;
        tick();
        chk("t5_rd_wen", rd_wen, 1);
        chk("t5_rd_addr", rd_addr, 7);
        claim_valid = 1'b1; claim_wide = 1'b0; claim_addr = 5'd7;
        tick();
        claim_valid = 1'b0;
        chk("t5_busy_set_wins", busy, 32'h0000_0080);
        tick();
        chk("t5_busy_still_set", busy, 32'h0000_0080);
        long_valid = 1'b1; long_addr = 5'd7; long_wdata = 64'h78;
        tick();
        long_valid = 1'b0;
        tick();
        tick();
        chk("t5_busy_final_clear", busy, 0);

        // 3. Pipe and long both valid every cycle: starvation relief and ordering
        li = 0;
        for (int c = 0; c < 13; c++) begin
            pipe_valid = 1'b1; pipe_wide = 1'b0; pipe_addr = 5'd10;
            pipe_wdata = 64'(32'hB000 + c);
            long_valid = 1'b1; long_wide = 1'b0; long_addr = 5'(16 + li);
            long_wdata = 64'(32'hA000 + li);
            chk($sformatf("t3_pipe_ready_c%0d", c), pipe_ready, exp_pr[c]);
            chk($sformatf("t3_long_ready_c%0d", c), long_ready, exp_lr[c]);
            if (exp_lr[c]) li++;
            tick();
            chk($sformatf("t3_rd_wen_c%0d", c), rd_wen, 1);
            if (c == 6) begin
                chk("t3_stall_addr_L0", rd_addr, 16);
                chk("t3_stall_data_L0", rd_wdata, 32'hA000);
            end else if (c == 12) begin
                chk("t3_stall_addr_L1", rd_addr, 17);
                chk("t3_stall_data_L1", rd_wdata, 32'hA001);
            end else begin
                chk($sformatf("t3_pipe_addr_c%0d", c), rd_addr, 10);
                chk($sformatf("t3_pipe_data_c%0d", c), rd_wdata, 32'hB000 + c);
            end
        end
        pipe_valid = 1'b0;
        long_valid = 1'b0;
        chk("t3_long_ready_after", long_ready, 1);
        tick();
        chk("t3_drain_rd_wen", rd_wen, 1);
        chk("t3_drain_addr_L2", rd_addr, 18);
        chk("t3_drain_data_L2", rd_wdata, 32'hA002);
        tick();
        chk("t3_drained_idle", rd_wen, 0);

        // 6. Reset with two buffered results and busy = 0x0F00
        claim_valid = 1'b1; claim_wide = 1'b1; claim_addr = 5'd8;
        tick();
        claim_addr = 5'd10;
        tick();
        claim_valid = 1'b0;
        chk("t6_busy_pre", busy, 32'h0000_0F00);
        pipe_valid = 1'b1; pipe_addr = 5'd12; pipe_wdata = 64'hC;
        long_valid = 1'b1; long_wide = 1'b1; long_addr = 5'd8; long_wdata = 64'h8;
        tick();
        long_addr = 5'd10; long_wdata = 64'hA;
        tick();
        pipe_valid = 1'b0;
        long_valid = 1'b0;
        chk("t6_fifo_full", long_ready, 0);
        g_reset = 1'b1;
        tick();
        g_reset = 1'b0;
        chk("t6_busy_reset", busy, 0);
        chk("t6_rd_wen_reset", rd_wen, 0);
        chk("t6_long_ready_reset", long_ready, 1);
        chk("t6_pipe_ready_reset", pipe_ready, 1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("t6_no_ghost_write_%0d", k), rd_wen, 0);
            chk($sformatf("t6_busy_zero_%0d", k), busy, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
